// File: rtl/ds_pkg.sv
// ds_pkg: types and constants shared by the DS decoder files.
//   sample_t   - signed 8-bit reconstructed sample
//   interval_t - unsigned 8-bit interval length (in samples)
//   ds_state_e - playback state (IDLE, RUN, STALL)
//   DEF_AMP    - default output magnitude
package ds_pkg;

   localparam int SAMPLE_W = 8;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic        [SAMPLE_W-1:0] interval_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } ds_state_e;

   localparam sample_t DEF_AMP = 8'sd64;

endpackage

// File: rtl/ds_decoder_if.sv
// ds_decoder_if: (S, D) input stream and reconstructed sample output of the
// DS decoder.
//   s_in     - crossing pulse, d_in valid while high
//   d_in     - interval length in samples
//   data_out - signed reconstructed sample
//   s_out    - one-cycle pulse on each reconstructed sign toggle
//   busy     - playback active (RUN or STALL)
//   ovf, udf - sticky drop / underrun flags     (DS_DEC_ERR_EN only)
//   clr_err  - clears ovf and udf               (DS_DEC_ERR_EN only)
// Modports: master = stream source / sample sink, slave = decoder.
interface ds_decoder_if;
   import ds_pkg::*;

   logic      s_in;
   interval_t d_in;
   sample_t   data_out;
   logic      s_out;
   logic      busy;
`ifdef DS_DEC_ERR_EN
   logic      ovf;
   logic      udf;
   logic      clr_err;
`endif

`ifdef DS_DEC_ERR_EN
   modport master (output s_in, d_in, clr_err,
                   input  data_out, s_out, busy, ovf, udf);
   modport slave  (input  s_in, d_in, clr_err,
                   output data_out, s_out, busy, ovf, udf);
`else
   modport master (output s_in, d_in,
                   input  data_out, s_out, busy);
   modport slave  (input  s_in, d_in,
                   output data_out, s_out, busy);
`endif

endinterface

// File: rtl/ds_interval_fifo.sv
// ds_interval_fifo: DEPTH x 8 synchronous FIFO of interval lengths.
//   clk, reset_n - clock, synchronous active-low reset (empties the FIFO)
//   push/wr_data - write request and data
//   pop/rd_data  - read request; rd_data shows the head entry (show-ahead)
//   full, empty  - occupancy flags
//   count        - number of stored entries (0..DEPTH)
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped.
module ds_interval_fifo
   import ds_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  interval_t                wr_data,
   input  logic                     pop,
   output interval_t                rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   interval_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          push_ok, pop_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ds_decoder.sv
// ds_decoder: rebuilds a signed square wave from an (S, D) zero-crossing
// stream. Intervals are queued in ds_interval_fifo and played back as
// +/-AMP levels whose sign toggles at each reconstructed crossing.
//   clk     - sample clock
//   reset_n - synchronous active-low reset
//   bus     - ds_decoder_if.slave (s_in, d_in, data_out, s_out, busy,
//             plus ovf, udf, clr_err when DS_DEC_ERR_EN is defined)
// Parameters: DEPTH (FIFO entries, power of two), PRIME (occupancy that
// starts playback), AMP (output magnitude).
// Optional feature macro: DS_DEC_ERR_EN adds the sticky ovf/udf flags.
module ds_decoder
   import ds_pkg::*;
#(
   parameter int      DEPTH = 4,
   parameter int      PRIME = 2,
   parameter sample_t AMP   = DEF_AMP
)(
   input  logic         clk,
   input  logic         reset_n,
   ds_decoder_if.slave  bus
);

   localparam int            CW        = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME);

   // A zero interval still occupies one sample.
   function automatic interval_t ivl_len(input interval_t d);
      return (d == '0) ? interval_t'(1) : d;
   endfunction

   function automatic sample_t level_of(input logic neg);
      return neg ? sample_t'(-AMP) : AMP;
   endfunction

   ds_state_e     state, nxt_state;
   interval_t     rd_data;
   interval_t     cnt_p1;
   logic [CW-1:0] count;
   logic          empty, full;
   logic          pop, load, toggle;
   logic          nxt_neg, last, primed;
   logic          neg_p1, tog_p1, busy_p1;
   sample_t       level_p1;

   ds_interval_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (bus.s_in),
      .wr_data (bus.d_in),
      .pop     (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign primed  = (count >= PRIME_CNT);
   // cnt_p1 is never zero in RUN, so 1 marks the final sample of the level.
   assign last    = (cnt_p1 == interval_t'(1));
   // The first interval after IDLE always starts positive.
   assign nxt_neg = toggle ? ~neg_p1 : 1'b0;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (primed)         nxt_state = RUN;
         RUN:     if (last && empty)  nxt_state = STALL;
         STALL:   if (!empty)         nxt_state = RUN;
         default:                     nxt_state = IDLE;
      endcase
   end

   always_comb begin
      pop    = 1'b0;
      load   = 1'b0;
      toggle = 1'b0;
      case (state)
         IDLE: begin
            if (primed) begin
               pop  = 1'b1;
               load = 1'b1;
            end
         end
         RUN: begin
            if (last && !empty) begin
               pop    = 1'b1;
               load   = 1'b1;
               toggle = 1'b1;
            end
         end
         STALL: begin
            if (!empty) begin
               pop    = 1'b1;
               load   = 1'b1;
               toggle = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---- stage p1: interval counter and registered outputs ----
   // Counter holds at 1 in STALL; it is only meaningful after a load.
   always_ff @(posedge clk) begin
      if (load)                      cnt_p1 <= ivl_len(rd_data);
      else if (state == RUN && !last) cnt_p1 <= cnt_p1 - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         neg_p1   <= 1'b0;
         tog_p1   <= 1'b0;
         busy_p1  <= 1'b0;
         level_p1 <= '0;
      end else begin
         tog_p1  <= toggle;
         busy_p1 <= (nxt_state != IDLE);
         if (load) begin
            neg_p1   <= nxt_neg;
            level_p1 <= level_of(nxt_neg);
         end
      end
   end

   assign bus.data_out = level_p1;
   assign bus.s_out    = tog_p1;
   assign bus.busy     = busy_p1;

`ifdef DS_DEC_ERR_EN
   logic drop, underrun, ovf_p1, udf_p1;

   assign drop     = bus.s_in && full && !pop;
   assign underrun = (state == RUN) && last && empty;

   // A new event in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovf_p1 <= 1'b0;
         udf_p1 <= 1'b0;
      end else begin
         ovf_p1 <= drop     | (ovf_p1 & ~bus.clr_err);
         udf_p1 <= underrun | (udf_p1 & ~bus.clr_err);
      end
   end

   assign bus.ovf = ovf_p1;
   assign bus.udf = udf_p1;
`else
   logic unused_full;
   assign unused_full = full;
`endif

endmodule
